// File: rtl/hazard_unit.sv
// Pipeline interlock for the 5-stage core: load-use / load-branch stalls,
// taken-branch IF/ID flush, data-memory freeze and saturating event counters.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_IFID,
  input  logic [4:0]       rs2_IFID,
  input  logic             rs1_used_IFID,
  input  logic             rs2_used_IFID,
  input  logic             IDControlBranch,
  input  logic             BranchTaken_ID,
  input  logic [4:0]       Rd_IDEX,
  input  logic             MemRead_IDEX,
  input  logic [4:0]       Rd_EXMEM,
  input  logic             MemRead_EXMEM,
  input  logic             dmem_busy,
  input  logic             clr_cnt,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state, state_next;
  logic [1:0] rem, rem_next;

  logic match_ex, match_mem;
  logic lb2, lb1, lu;
  logic stall, flush;

  // x0 never creates a dependency, and an unread source register never matches
  assign match_ex  = (Rd_IDEX != 5'd0) &&
                     ((rs1_used_IFID && (rs1_IFID == Rd_IDEX)) ||
                      (rs2_used_IFID && (rs2_IFID == Rd_IDEX)));
  assign match_mem = (Rd_EXMEM != 5'd0) &&
                     ((rs1_used_IFID && (rs1_IFID == Rd_EXMEM)) ||
                      (rs2_used_IFID && (rs2_IFID == Rd_EXMEM)));

  assign lb2 = IDControlBranch && MemRead_IDEX && match_ex;
  assign lb1 = IDControlBranch && MemRead_EXMEM && match_mem;
  assign lu  = !IDControlBranch && MemRead_IDEX && match_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // A frozen cycle leaves state and rem untouched so the stall resumes intact
  always_comb begin
    state_next = state;
    rem_next   = rem;
    stall      = 1'b0;
    if (!rst && !dmem_busy) begin
      case (state)
        RUN: begin
          if (lb2) begin
            stall      = 1'b1;
            state_next = HOLD;
            rem_next   = 2'd1;
          end else if (lb1 || lu) begin
            stall = 1'b1;
          end
        end
        HOLD: begin
          stall = 1'b1;
          if (rem <= 2'd1) begin
            state_next = RUN;
            rem_next   = 2'd0;
          end else begin
            rem_next = rem - 2'd1;
          end
        end
        default: begin
          state_next = RUN;
          rem_next   = 2'd0;
        end
      endcase
    end
  end

  assign flush       = !rst && !dmem_busy && !stall && IDControlBranch && BranchTaken_ID;
  assign freeze      = !rst && dmem_busy;
  assign PCWrite     = !(stall || freeze);
  assign IFIDWrite   = !(stall || freeze);
  assign IDEX_bubble = stall;
  assign IFID_flush  = flush;

  // Clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second 3-bit-counter
// instance shares the stimulus so counter saturation is reachable quickly.
module tb_hazard_unit;

  localparam logic [4:0] IDLE   = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00100;
  localparam logic [4:0] FLUSH  = 5'b11010;
  localparam logic [4:0] FREEZE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_IFID, rs2_IFID, Rd_IDEX, Rd_EXMEM;
  logic        rs1_used_IFID, rs2_used_IFID;
  logic        IDControlBranch, BranchTaken_ID;
  logic        MemRead_IDEX, MemRead_EXMEM;
  logic        dmem_busy, clr_cnt;

  logic        PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, freeze;
  logic [31:0] stall_cycles, flush_count;
  logic        s_PCWrite, s_IFIDWrite, s_IDEX_bubble, s_IFID_flush, s_freeze;
  logic [2:0]  s_stall_cycles, s_flush_count;

  logic [4:0]  ctl, s_ctl;
  int          errors = 0;
  int          checks = 0;

  assign ctl   = {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, freeze};
  assign s_ctl = {s_PCWrite, s_IFIDWrite, s_IDEX_bubble, s_IFID_flush, s_freeze};

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_used_IFID(rs1_used_IFID), .rs2_used_IFID(rs2_used_IFID),
    .IDControlBranch(IDControlBranch), .BranchTaken_ID(BranchTaken_ID),
    .Rd_IDEX(Rd_IDEX), .MemRead_IDEX(MemRead_IDEX),
    .Rd_EXMEM(Rd_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
    .dmem_busy(dmem_busy), .clr_cnt(clr_cnt),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_bubble(IDEX_bubble),
    .IFID_flush(IFID_flush), .freeze(freeze),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_unit #(.CNT_W(3)) sat_dut (
    .clk(clk), .rst(rst),
    .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_used_IFID(rs1_used_IFID), .rs2_used_IFID(rs2_used_IFID),
    .IDControlBranch(IDControlBranch), .BranchTaken_ID(BranchTaken_ID),
    .Rd_IDEX(Rd_IDEX), .MemRead_IDEX(MemRead_IDEX),
    .Rd_EXMEM(Rd_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
    .dmem_busy(dmem_busy), .clr_cnt(clr_cnt),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEX_bubble(s_IDEX_bubble),
    .IFID_flush(s_IFID_flush), .freeze(s_freeze),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs1_IFID = 5'd0; rs2_IFID = 5'd0;
    rs1_used_IFID = 1'b0; rs2_used_IFID = 1'b0;
    IDControlBranch = 1'b0; BranchTaken_ID = 1'b0;
    Rd_IDEX = 5'd0; MemRead_IDEX = 1'b0;
    Rd_EXMEM = 5'd0; MemRead_EXMEM = 1'b0;
    dmem_busy = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    clear_inputs();
    clr_cnt = 1'b1;
  endtask

  // Load in EX, branch in ID reading it through rs1
  task automatic set_lb2(input logic [4:0] r);
    IDControlBranch = 1'b1;
    rs1_IFID = r; rs1_used_IFID = 1'b1;
    rs2_IFID = 5'd8; rs2_used_IFID = 1'b1;
    Rd_IDEX = r; MemRead_IDEX = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rs1_IFID = 5'd5; rs1_used_IFID = 1'b1; Rd_IDEX = 5'd5; MemRead_IDEX = 1'b1;
    dmem_busy = 1'b1;
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, IDLE);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    checks++;
    if (s_stall_cycles !== 3'd0 || s_flush_count !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_sat_cnt: got %0d/%0d expected 0/0", s_stall_cycles, s_flush_count);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    rs1_IFID = 5'd5; rs1_used_IFID = 1'b1; rs2_IFID = 5'd6; rs2_used_IFID = 1'b1;
    Rd_IDEX = 5'd5; MemRead_IDEX = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL lu_stall: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("[TB] FAIL lu_count: got %0d expected 1", stall_cycles);
    end
    clear_inputs();
    rs1_IFID = 5'd5; rs1_used_IFID = 1'b1; Rd_EXMEM = 5'd5; MemRead_EXMEM = 1'b1;
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("[TB] FAIL lu_after: got %b expected %b", ctl, IDLE);
    end
  endtask

  task automatic test_load_branch2();
    clear_counters();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("[TB] FAIL clr_cnt: got %0d expected 0", stall_cycles);
    end
    clear_inputs();
    set_lb2(5'd7);
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL lb2_first: got %b expected %b", ctl, STALL);
    end
    // Second cycle carries no hazard on the inputs: only HOLD can stall it
    @(negedge clk);
    clear_inputs();
    IDControlBranch = 1'b1; rs1_IFID = 5'd7; rs1_used_IFID = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL lb2_hold: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++; $display("[TB] FAIL lb2_count: got %0d expected 2", stall_cycles);
    end
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("[TB] FAIL lb2_release: got %b expected %b", ctl, IDLE);
    end
  endtask

  task automatic test_load_branch1_flush();
    clear_counters();
    @(negedge clk);
    clear_inputs();
    IDControlBranch = 1'b1; BranchTaken_ID = 1'b1;
    rs1_IFID = 5'd3; rs1_used_IFID = 1'b1; rs2_IFID = 5'd4; rs2_used_IFID = 1'b1;
    Rd_EXMEM = 5'd3; MemRead_EXMEM = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL lb1_stall_no_flush: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    MemRead_EXMEM = 1'b0; Rd_EXMEM = 5'd0;
    #1;
    checks++;
    if (ctl !== FLUSH) begin
      errors++; $display("[TB] FAIL lb1_flush: got %b expected %b", ctl, FLUSH);
    end
    @(negedge clk);
    checks++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd1) begin
      errors++; $display("[TB] FAIL lb1_counts: got flush=%0d stall=%0d expected 1/1", flush_count, stall_cycles);
    end
    clear_inputs();
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("[TB] FAIL lb1_idle: got %b expected %b", ctl, IDLE);
    end
  endtask

  task automatic test_freeze_in_lb2();
    clear_counters();
    @(negedge clk);
    clear_inputs();
    set_lb2(5'd7);
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL frz_lb2_first: got %b expected %b", ctl, STALL);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cycles !== 32'd1 || flush_count !== 32'd0) begin
        errors++; $display("[TB] FAIL frz_cnt_hold[%0d]: got stall=%0d flush=%0d expected 1/0", i, stall_cycles, flush_count);
      end
      clear_inputs();
      set_lb2(5'd7);
      BranchTaken_ID = 1'b1; dmem_busy = 1'b1;
      #1;
      checks++;
      if (ctl !== FREEZE) begin
        errors++; $display("[TB] FAIL frz_ctl[%0d]: got %b expected %b", i, ctl, FREEZE);
      end
    end
    @(negedge clk);
    clear_inputs();
    IDControlBranch = 1'b1; BranchTaken_ID = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL frz_resume_stall: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++; $display("[TB] FAIL frz_stall_count: got %0d expected 2", stall_cycles);
    end
    #1;
    checks++;
    if (ctl !== FLUSH) begin
      errors++; $display("[TB] FAIL frz_then_flush: got %b expected %b", ctl, FLUSH);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_no_stall();
    clear_counters();
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      clear_inputs();
      case (p)
        0: begin rs1_used_IFID = 1'b1; Rd_IDEX = 5'd0; MemRead_IDEX = 1'b1; end
        1: begin rs1_IFID = 5'd4; rs1_used_IFID = 1'b1; rs2_IFID = 5'd9;
                 Rd_IDEX = 5'd9; MemRead_IDEX = 1'b1; end
        2: begin IDControlBranch = 1'b1; rs1_IFID = 5'd6; rs1_used_IFID = 1'b1;
                 Rd_IDEX = 5'd6; Rd_EXMEM = 5'd6; end
        default: begin rs1_IFID = 5'd11; rs1_used_IFID = 1'b1;
                 Rd_EXMEM = 5'd11; MemRead_EXMEM = 1'b1; end
      endcase
      #1;
      checks++;
      if (ctl !== IDLE) begin
        errors++; $display("[TB] FAIL no_stall[%0d]: got %b expected %b", p, ctl, IDLE);
      end
    end
    @(negedge clk);
    clear_inputs();
    rs2_IFID = 5'd9; rs2_used_IFID = 1'b1; Rd_IDEX = 5'd9; MemRead_IDEX = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL lu_rs2: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("[TB] FAIL no_stall_count: got %0d expected 1", stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clear_inputs();
      rs2_IFID = 5'd12; rs2_used_IFID = 1'b1; Rd_IDEX = 5'd12; MemRead_IDEX = 1'b1;
      #1;
      checks++;
      if (s_ctl !== STALL) begin
        errors++; $display("[TB] FAIL sat_lu_ctl[%0d]: got %b expected %b", i, s_ctl, STALL);
      end
    end
    @(negedge clk);
    checks++;
    if (s_stall_cycles !== 3'd7 || stall_cycles !== 32'd9) begin
      errors++; $display("[TB] FAIL sat_stall: got %0d/%0d expected 7/9", s_stall_cycles, stall_cycles);
    end
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      IDControlBranch = 1'b1; BranchTaken_ID = 1'b1;
      #1;
      checks++;
      if (ctl !== FLUSH) begin
        errors++; $display("[TB] FAIL sat_flush_ctl[%0d]: got %b expected %b", i, ctl, FLUSH);
      end
      @(negedge clk);
    end
    checks++;
    if (s_flush_count !== 3'd7 || flush_count !== 32'd9 || s_stall_cycles !== 3'd7) begin
      errors++; $display("[TB] FAIL sat_flush: got %0d/%0d stall=%0d expected 7/9 stall=7", s_flush_count, flush_count, s_stall_cycles);
    end
    clear_inputs();
    rs1_IFID = 5'd12; rs1_used_IFID = 1'b1; Rd_IDEX = 5'd12; MemRead_IDEX = 1'b1;
    clr_cnt = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL clr_with_stall_ctl: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0 || s_stall_cycles !== 3'd0 || flush_count !== 32'd0) begin
      errors++; $display("[TB] FAIL clr_priority: got %0d/%0d/%0d expected 0/0/0", stall_cycles, s_stall_cycles, flush_count);
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk);
    clear_inputs();
    set_lb2(5'd7);
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL rh_lb2: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("[TB] FAIL rh_forced_idle: got %b expected %b", ctl, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctl !== IDLE || stall_cycles !== 32'd0) begin
      errors++; $display("[TB] FAIL rh_resume_idle: got %b cnt=%0d expected %b cnt=0", ctl, stall_cycles, IDLE);
    end
    @(negedge clk);
    rs1_IFID = 5'd5; rs1_used_IFID = 1'b1; Rd_IDEX = 5'd5; MemRead_IDEX = 1'b1;
    #1;
    checks++;
    if (ctl !== STALL) begin
      errors++; $display("[TB] FAIL rh_detect_resumes: got %b expected %b", ctl, STALL);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_branch2();
    test_load_branch1_flush();
    test_freeze_in_lb2();
    test_no_stall();
    test_saturation();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
